// File: rtl/fc_layer_pkg.sv
// Shared types and arithmetic helpers for the streaming fully-connected layer.
package fc_layer_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, FINAL, DRAIN} state_t;

  localparam int unsigned SAT_W = 64;

  // Accumulator width that cannot overflow for n_in signed products plus a bias.
  function automatic int acc_w(input int width, input int n_in);
    return 2 * width + $clog2(n_in) + 1;
  endfunction

  // Arithmetic shift right by frac, then clamp to the signed range of width bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                        input int unsigned frac,
                                                        input int unsigned width);
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> frac;
    hi = $signed((64'd1 << (width - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (sh > hi) return hi;
    else if (sh < lo) return lo;
    else return sh;
  endfunction

endpackage

// File: rtl/fc_layer_stream_if.sv
// Stream-in / stream-out / configuration bundle of fc_layer_stream.
interface fc_layer_stream_if #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 8
);
  localparam int CFG_AW = $clog2(N_IN * N_OUT);

  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  data_in;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  data_out;
  logic              cfg_we;
  logic              cfg_sel;
  logic [CFG_AW-1:0] cfg_addr;
  logic [WIDTH-1:0]  cfg_data;
  logic              cfg_ready;

  modport master (
    output s_valid, data_in, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  s_ready, m_valid, data_out, cfg_ready
  );

  modport slave (
    input  s_valid, data_in, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output s_ready, m_valid, data_out, cfg_ready
  );
endinterface

// File: rtl/fc_mac_lane.sv
// One MAC lane: weight bank, bias store, registered multiply, accumulator, post-processing.
// FC_LAYER_RELU_EN: clamp negative accumulators to zero before shift/saturate.
module fc_mac_lane
  import fc_layer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int P     = 4,
  parameter int FRAC  = 0,
  parameter int ACC_W = acc_w(WIDTH, N_IN),
  parameter int AW    = $clog2((N_OUT / P) * N_IN),
  parameter int GW    = ((N_OUT / P) > 1) ? $clog2(N_OUT / P) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_waddr,
  input  logic                    b_we,
  input  logic [GW-1:0]           b_waddr,
  input  logic [WIDTH-1:0]        cfg_data,
  input  logic [AW-1:0]           w_raddr,
  input  logic [GW-1:0]           grp,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    acc_init,
  input  logic                    add_en,
  input  logic                    final_en,
  output logic signed [WIDTH-1:0] out_val
);
  localparam int NGRP  = N_OUT / P;
  localparam int DEPTH = NGRP * N_IN;

  logic signed [WIDTH-1:0]   w_mem [DEPTH];
  logic signed [WIDTH-1:0]   b_mem [NGRP];
  logic signed [WIDTH-1:0]   w_rd_d, w_rd_q;
  logic signed [2*WIDTH-1:0] mul_d, mul_q;
  logic signed [ACC_W-1:0]   acc_d, acc_q, acc_post;
  logic signed [WIDTH-1:0]   out_d, out_q;

  // Parameter storage survives reset so a layer need not be reloaded.
  always_ff @(posedge clk) begin
    if (w_we) w_mem[w_waddr] <= cfg_data;
    if (b_we) b_mem[b_waddr] <= cfg_data;
  end

  always_comb begin
    w_rd_d = w_mem[w_raddr];
    mul_d  = w_rd_q * x_in;
    acc_d  = acc_q;
    if (acc_init)    acc_d = ACC_W'(b_mem[grp]);
    else if (add_en) acc_d = acc_q + ACC_W'(mul_q);
    acc_post = acc_q;
`ifdef FC_LAYER_RELU_EN
    if (acc_q < 0) acc_post = '0;
`endif
    out_d = out_q;
    if (final_en) out_d = WIDTH'(sat_shift(64'(acc_post), FRAC, WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_rd_q <= '0;
      mul_q  <= '0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      w_rd_q <= w_rd_d;
      mul_q  <= mul_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign out_val = out_q;
endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: y = sat(relu?(W*x + b) >>> FRAC), P outputs per pass.
// FC_LAYER_RELU_EN (optional define): enables ReLU in the lane post-processing.
module fc_layer_stream
  import fc_layer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int P     = 4,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  fc_layer_stream_if.slave bus
);
  localparam int ACC_W  = acc_w(WIDTH, N_IN);
  localparam int NGRP   = N_OUT / P;
  localparam int GW     = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int AW     = $clog2(NGRP * N_IN);
  localparam int IN_W   = $clog2(N_IN);
  localparam int CMP_W  = $clog2(N_IN + 2);
  localparam int OUT_W  = (P > 1) ? $clog2(P) : 1;

  if ((N_OUT % P) != 0 || P < 1 || P > N_OUT || N_IN < 2) begin : g_param_err
    $error("fc_layer_stream: need N_IN >= 2, 1 <= P <= N_OUT and N_OUT a multiple of P");
  end

  state_t                  state_q, state_d;
  logic [IN_W-1:0]         in_cnt_q, in_cnt_d;
  logic [CMP_W-1:0]        cmp_cnt_q, cmp_cnt_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;
  logic signed [WIDTH-1:0] x_q [N_IN];
  logic signed [WIDTH-1:0] x_d [N_IN];
  logic signed [WIDTH-1:0] x_rd_q, x_rd_d;
  logic                    s_hs, m_hs, cfg_ok;
  logic                    acc_init, add_en, final_en;
  logic [IN_W-1:0]         rd_idx;
  logic [AW-1:0]           rd_addr;
  logic [P-1:0]            w_we, b_we;
  logic [AW-1:0]           w_waddr;
  logic [GW-1:0]           b_waddr;
  logic signed [WIDTH-1:0] lane_out [P];

  assign s_hs = bus.s_valid && (state_q == LOAD);
  assign m_hs = bus.m_ready && (state_q == DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      cmp_cnt_q <= '0;
      grp_q     <= '0;
      out_cnt_q <= '0;
      x_rd_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      grp_q     <= grp_d;
      out_cnt_q <= out_cnt_d;
      x_rd_q    <= x_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    grp_d     = grp_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      LOAD: begin
        if (s_hs) begin
          if (in_cnt_q == IN_W'(N_IN - 1)) begin
            in_cnt_d  = '0;
            cmp_cnt_d = '0;
            state_d   = COMPUTE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (cmp_cnt_q == CMP_W'(N_IN + 1)) state_d = FINAL;
        else cmp_cnt_d = cmp_cnt_q + 1'b1;
      end
      FINAL: begin
        out_cnt_d = '0;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (m_hs) begin
          if (out_cnt_q == OUT_W'(P - 1)) begin
            out_cnt_d = '0;
            if (grp_q == GW'(NGRP - 1)) begin
              grp_d   = '0;
              state_d = LOAD;
            end else begin
              grp_d     = grp_q + 1'b1;
              cmp_cnt_d = '0;
              state_d   = COMPUTE;
            end
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    bus.s_ready   = (state_q == LOAD);
    bus.cfg_ready = (state_q == LOAD) && (in_cnt_q == '0);
    bus.m_valid   = (state_q == DRAIN);
    bus.data_out  = (state_q == DRAIN) ? lane_out[out_cnt_q] : '0;
    acc_init      = (state_q == COMPUTE) && (cmp_cnt_q == '0);
    add_en        = (state_q == COMPUTE) && (cmp_cnt_q >= CMP_W'(2));
    final_en      = (state_q == FINAL);
  end

  // Element index and weight address are registered together so x and W meet in the multiplier.
  always_comb begin
    x_d = x_q;
    if (s_hs) x_d[in_cnt_q] = bus.data_in;
    rd_idx  = (cmp_cnt_q < CMP_W'(N_IN)) ? IN_W'(cmp_cnt_q) : '0;
    x_rd_d  = x_q[rd_idx];
    rd_addr = AW'(int'(grp_q) * N_IN + int'(rd_idx));
  end

  // Row o lives in bank o%P at row-group o/P.
  always_comb begin
    int unsigned a, o, i;
    cfg_ok  = bus.cfg_we && (state_q == LOAD) && (in_cnt_q == '0);
    w_we    = '0;
    b_we    = '0;
    a       = 32'(bus.cfg_addr);
    o       = a / N_IN;
    i       = a % N_IN;
    w_waddr = AW'((o / P) * N_IN + i);
    b_waddr = GW'(a / P);
    if (cfg_ok && !bus.cfg_sel && a < N_IN * N_OUT) w_we[OUT_W'(o % P)] = 1'b1;
    if (cfg_ok && bus.cfg_sel && a < N_OUT)         b_we[OUT_W'(a % P)] = 1'b1;
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    fc_mac_lane #(
      .WIDTH(WIDTH),
      .N_IN (N_IN),
      .N_OUT(N_OUT),
      .P    (P),
      .FRAC (FRAC),
      .ACC_W(ACC_W),
      .AW   (AW),
      .GW   (GW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .w_we    (w_we[k]),
      .w_waddr (w_waddr),
      .b_we    (b_we[k]),
      .b_waddr (b_waddr),
      .cfg_data(bus.cfg_data),
      .w_raddr (rd_addr),
      .grp     (grp_q),
      .x_in    (x_rd_q),
      .acc_init(acc_init),
      .add_en  (add_en),
      .final_en(final_en),
      .out_val (lane_out[k])
    );
  end
endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream: a FRAC=0 and a FRAC=8 instance share one stimulus port.
module tb_fc_layer_stream;
  localparam int WIDTH = 16;
  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int P     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             sel = 1'b0;
  logic             s_valid = 1'b0, m_ready = 1'b0, cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [WIDTH-1:0] data_in = '0, cfg_data = '0;
  logic [3:0]       cfg_addr = '0;
  logic             s_ready, m_valid, cfg_ready;
  logic [WIDTH-1:0] data_out;

  fc_layer_stream_if #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT)) bus0 ();
  fc_layer_stream_if #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT)) bus8 ();

  assign bus0.s_valid  = s_valid & ~sel;
  assign bus0.m_ready  = m_ready & ~sel;
  assign bus0.cfg_we   = cfg_we & ~sel;
  assign bus0.data_in  = data_in;
  assign bus0.cfg_sel  = cfg_sel;
  assign bus0.cfg_addr = cfg_addr;
  assign bus0.cfg_data = cfg_data;
  assign bus8.s_valid  = s_valid & sel;
  assign bus8.m_ready  = m_ready & sel;
  assign bus8.cfg_we   = cfg_we & sel;
  assign bus8.data_in  = data_in;
  assign bus8.cfg_sel  = cfg_sel;
  assign bus8.cfg_addr = cfg_addr;
  assign bus8.cfg_data = cfg_data;

  assign s_ready   = sel ? bus8.s_ready   : bus0.s_ready;
  assign m_valid   = sel ? bus8.m_valid   : bus0.m_valid;
  assign cfg_ready = sel ? bus8.cfg_ready : bus0.cfg_ready;
  assign data_out  = sel ? bus8.data_out  : bus0.data_out;

  fc_layer_stream #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .P(P), .FRAC(0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  fc_layer_stream #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .P(P), .FRAC(8)) u_dut_frac (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  int n_checks = 0;
  int n_fail = 0;
  int w_tab [16];
  int b_tab [4];
  int x_tab [4];
  int exp_tab [4];
  int last_hs = 0;

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic cfg_write(input logic s, input int a, input int d);
    cfg_we   = 1'b1;
    cfg_sel  = s;
    cfg_addr = 4'(a);
    cfg_data = 16'(d);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg();
    for (int a = 0; a < 16; a++) cfg_write(1'b0, a, w_tab[a]);
    for (int o = 0; o < 4; o++) cfg_write(1'b1, o, b_tab[o]);
  endtask

  task automatic set_identity(input int scale);
    for (int a = 0; a < 16; a++) w_tab[a] = ((a / 4) == (a % 4)) ? scale : 0;
    for (int o = 0; o < 4; o++) b_tab[o] = 0;
  endtask

  task automatic send_vec();
    for (int i = 0; i < N_IN; i++) begin
      int t;
      t = 0;
      s_valid = 1'b1;
      data_in = 16'(x_tab[i]);
      while (!s_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) check("s_ready_wait", 0, 1);
      @(posedge clk);
      @(negedge clk);
      if (i == 0) check("cfg_ready_busy", int'(cfg_ready), 0);
    end
    s_valid = 1'b0;
    last_hs = cyc;
  endtask

  task automatic recv(input int n, input int stall_at, input bit chk_lat);
    m_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      int t;
      t = 0;
      while (!m_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("m_valid_%0d", j), int'(m_valid), 1);
      if (chk_lat && j == 0) check("latency_first", cyc - last_hs, N_IN + 3);
      if (chk_lat && j == P) check("latency_group", cyc - last_hs, N_IN + 3);
      if (j == stall_at) begin
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_data", $signed(data_out), exp_tab[j]);
        end
        check("stall_valid", int'(m_valid), 1);
        m_ready = 1'b1;
      end
      check($sformatf("out_%0d", j), $signed(data_out), exp_tab[j]);
      @(posedge clk);
      @(negedge clk);
      last_hs = cyc;
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_data_out", $signed(data_out), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    // identity weights, with latency
    set_identity(1);
    load_cfg();
    x_tab = '{1, 2, 3, 4};
    exp_tab = '{1, 2, 3, 4};
    send_vec();
    recv(4, -1, 1'b1);
    check("back_to_load_s_ready", int'(s_ready), 1);
    check("back_to_load_m_valid", int'(m_valid), 0);

    // all-ones rows with signed bias
    for (int a = 0; a < 16; a++) w_tab[a] = 1;
    b_tab = '{10, -20, 0, 5};
    load_cfg();
    x_tab = '{1, 1, 1, 1};
`ifdef FC_LAYER_RELU_EN
    exp_tab = '{14, 0, 4, 9};
`else
    exp_tab = '{14, -16, 4, 9};
`endif
    send_vec();
    recv(4, -1, 1'b0);

    // positive and negative saturation
    for (int a = 0; a < 16; a++) w_tab[a] = 32767;
    b_tab = '{0, 0, 0, 0};
    load_cfg();
    x_tab = '{32767, 32767, 32767, 32767};
    exp_tab = '{32767, 32767, 32767, 32767};
    send_vec();
    recv(4, -1, 1'b0);
    x_tab = '{-32768, -32768, -32768, -32768};
`ifdef FC_LAYER_RELU_EN
    exp_tab = '{0, 0, 0, 0};
`else
    exp_tab = '{-32768, -32768, -32768, -32768};
`endif
    send_vec();
    recv(4, -1, 1'b0);

    // s_valid during COMPUTE and cfg_we during DRAIN are ignored
    set_identity(1);
    load_cfg();
    x_tab = '{5, 6, 7, 8};
    exp_tab = '{5, 6, 7, 8};
    send_vec();
    s_valid = 1'b1;
    data_in = 16'd99;
    check("compute_s_ready", int'(s_ready), 0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
    check("drain_cfg_ready", int'(cfg_ready), 0);
    cfg_write(1'b0, 0, 100);
    recv(4, -1, 1'b0);
    cfg_write(1'b1, 4, 77);
    x_tab = '{1, 2, 3, 4};
    exp_tab = '{1, 2, 3, 4};
    send_vec();
    recv(4, -1, 1'b0);

    // reset while group 1 computes
    send_vec();
    recv(2, -1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    check("midrst_cfg_ready", int'(cfg_ready), 1);
    x_tab = '{4, 3, 2, 1};
    exp_tab = '{4, 3, 2, 1};
    send_vec();
    recv(4, -1, 1'b1);

    // FRAC=8 instance, downstream stall mid-drain
    sel = 1'b1;
    @(negedge clk);
    set_identity(256);
    load_cfg();
    x_tab = '{512, -768, 3, 0};
`ifdef FC_LAYER_RELU_EN
    exp_tab = '{512, 0, 3, 0};
`else
    exp_tab = '{512, -768, 3, 0};
`endif
    send_vec();
    recv(4, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
